// File: rtl/ps2_key_ctrl.sv
// PS/2 keyboard front end: pin synchroniser, 11-bit frame receiver with timeout,
// and a make/break key-state machine feeding the seven-segment decoders.
module ps2_key_ctrl #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       code_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err,
  output logic [7:0] key_code,
  output logic [7:0] key_cnt,
  output logic       key_down,
  output logic       seg_blank
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DOWN = 2'd1,
    BRK  = 2'd2
  } state_t;

  logic [2:0]    s_q, s_d;
  logic [3:0]    bcnt_q, bcnt_d;
  logic [9:0]    buf_q, buf_d;
  logic [TW-1:0] idle_q, idle_d;
  logic [7:0]    rx_q, rx_d;
  logic          cv_q, cv_d;
  logic          fe_q, fe_d;
  state_t        state_q, state_d;
  logic [7:0]    code_q, code_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          sample;
  logic          frame_ok;

  assign sample   = s_q[2] & ~s_q[1];
  // Stop bit is read live from the pin on the final sample, not from the buffer.
  assign frame_ok = ~buf_q[0] & ps2_data & (^buf_q[9:1]);

  always_comb begin
    s_d    = {s_q[1:0], ps2_clk};
    bcnt_d = bcnt_q;
    buf_d  = buf_q;
    idle_d = idle_q;
    rx_d   = rx_q;
    cv_d   = 1'b0;
    fe_d   = 1'b0;
    if (sample) begin
      idle_d = '0;
      if (bcnt_q < 4'd10) begin
        buf_d[bcnt_q] = ps2_data;
        bcnt_d        = bcnt_q + 4'd1;
      end else begin
        bcnt_d = 4'd0;
        if (frame_ok) begin
          rx_d = buf_q[8:1];
          cv_d = 1'b1;
        end else begin
          fe_d = 1'b1;
        end
      end
    end else if (bcnt_q != 4'd0) begin
      if (idle_q == TW'(TIMEOUT_CYC)) begin
        bcnt_d = 4'd0;
        idle_d = '0;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
  end

  // E0 prefixes are transparent; in BRK the next byte is the released key's code.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    if (cv_q && (rx_q != 8'hE0)) begin
      case (state_q)
        IDLE: begin
          if (rx_q == 8'hF0) begin
            state_d = BRK;
          end else begin
            state_d = DOWN;
            code_d  = rx_q;
            cnt_d   = cnt_q + 8'd1;
          end
        end
        DOWN: begin
          if (rx_q == 8'hF0) begin
            state_d = BRK;
          end else if (rx_q != code_q) begin
            code_d = rx_q;
            cnt_d  = cnt_q + 8'd1;
          end
        end
        BRK:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      s_q     <= 3'b111;
      bcnt_q  <= 4'd0;
      buf_q   <= 10'd0;
      idle_q  <= '0;
      rx_q    <= 8'h00;
      cv_q    <= 1'b0;
      fe_q    <= 1'b0;
      state_q <= IDLE;
      code_q  <= 8'h00;
      cnt_q   <= 8'h00;
    end else begin
      s_q     <= s_d;
      bcnt_q  <= bcnt_d;
      buf_q   <= buf_d;
      idle_q  <= idle_d;
      rx_q    <= rx_d;
      cv_q    <= cv_d;
      fe_q    <= fe_d;
      state_q <= state_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
    end
  end

  assign code_valid = cv_q;
  assign frame_err  = fe_q;
  assign rx_byte    = rx_q;
  assign key_code   = code_q;
  assign key_cnt    = cnt_q;
  assign key_down   = (state_q != IDLE);
  assign seg_blank  = (state_q == IDLE);

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed self-checking bench for ps2_key_ctrl: frames are bit-banged on the
// PS/2 pins and key state is checked against hand-computed values.
module tb_ps2_key_ctrl;

  localparam int TO   = 40;
  localparam int HALF = 4;

  logic       clk;
  logic       clrn;
  logic       ps2_clk;
  logic       ps2_data;
  logic       code_valid;
  logic [7:0] rx_byte;
  logic       frame_err;
  logic [7:0] key_code;
  logic [7:0] key_cnt;
  logic       key_down;
  logic       seg_blank;

  int testsRun  = 0;
  int testsFail = 0;
  int cvCount   = 0;
  int feCount   = 0;
  int bothCount = 0;
  int longCount = 0;
  logic prevCv  = 1'b0;
  logic prevFe  = 1'b0;
  int cvBase;
  int feBase;

  ps2_key_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .code_valid(code_valid),
    .rx_byte   (rx_byte),
    .frame_err (frame_err),
    .key_code  (key_code),
    .key_cnt   (key_cnt),
    .key_down  (key_down),
    .seg_blank (seg_blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: run did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  // Pulse monitor, sampled on the falling clk edge away from DUT updates.
  always @(negedge clk) begin
    if (code_valid) cvCount++;
    if (frame_err) feCount++;
    if (code_valid && frame_err) bothCount++;
    if ((code_valid && prevCv) || (frame_err && prevFe)) longCount++;
    prevCv = code_valid;
    prevFe = frame_err;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Sends the first nbits bits of a frame carrying b (start, data LSB first, odd parity, stop).
  task automatic applyStimulus(input logic [7:0] b, input bit flipPar, input bit badStop,
                               input int nbits);
    logic [10:0] f;
    f = {~badStop, (~^b) ^ flipPar, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    repeat (HALF) @(negedge clk);
    ps2_data = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic sendByte(input logic [7:0] b);
    applyStimulus(b, 1'b0, 1'b0, 11);
  endtask

  task automatic doReset();
    clrn = 1'b0;
    repeat (3) @(negedge clk);
    clrn = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    clrn     = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    clrn = 1'b1;
    repeat (50) @(negedge clk);

    checkOutput("reset_seg_blank", seg_blank, 1);
    checkOutput("reset_key_down", key_down, 0);
    checkOutput("reset_key_cnt", key_cnt, 8'h00);
    checkOutput("reset_key_code", key_code, 8'h00);
    checkOutput("reset_rx_byte", rx_byte, 8'h00);
    checkOutput("reset_no_pulses", cvCount + feCount, 0);

    // Reset during bit 5 drops the partial frame.
    applyStimulus(8'h1C, 1'b0, 1'b0, 5);
    ps2_data = 1'b1;
    doReset();
    cvBase = cvCount;
    sendByte(8'h1C);
    checkOutput("midreset_one_valid", cvCount - cvBase, 1);
    checkOutput("midreset_rx_byte", rx_byte, 8'h1C);
    checkOutput("press_key_code", key_code, 8'h1C);
    checkOutput("press_key_cnt", key_cnt, 8'h01);
    checkOutput("press_key_down", key_down, 1);
    checkOutput("press_seg_blank", seg_blank, 0);

    sendByte(8'h1C);
    sendByte(8'h1C);
    checkOutput("repeat_key_cnt", key_cnt, 8'h01);
    sendByte(8'hF0);
    checkOutput("brk_key_down", key_down, 1);
    sendByte(8'h1C);
    checkOutput("release_key_cnt", key_cnt, 8'h01);
    checkOutput("release_key_down", key_down, 0);
    checkOutput("release_seg_blank", seg_blank, 1);
    checkOutput("release_key_code", key_code, 8'h1C);

    cvBase = cvCount;
    feBase = feCount;
    applyStimulus(8'h1C, 1'b1, 1'b0, 11);
    checkOutput("parity_frame_err", feCount - feBase, 1);
    checkOutput("parity_no_valid", cvCount - cvBase, 0);
    checkOutput("parity_key_down", key_down, 0);
    checkOutput("parity_key_cnt", key_cnt, 8'h01);
    applyStimulus(8'h2A, 1'b0, 1'b1, 11);
    checkOutput("stop_frame_err", feCount - feBase, 2);
    checkOutput("stop_no_valid", cvCount - cvBase, 0);
    checkOutput("err_rx_byte_held", rx_byte, 8'h1C);

    // Stalled partial frame must be abandoned silently by the timeout.
    cvBase = cvCount;
    feBase = feCount;
    applyStimulus(8'h55, 1'b0, 1'b0, 6);
    repeat (TO * 3) @(negedge clk);
    sendByte(8'h32);
    checkOutput("timeout_one_valid", cvCount - cvBase, 1);
    checkOutput("timeout_no_err", feCount - feBase, 0);
    checkOutput("timeout_rx_byte", rx_byte, 8'h32);
    checkOutput("timeout_key_cnt", key_cnt, 8'h02);
    sendByte(8'h45);
    checkOutput("newkey_key_code", key_code, 8'h45);
    checkOutput("newkey_key_cnt", key_cnt, 8'h03);

    doReset();
    for (int i = 0; i < 256; i++) begin
      sendByte(8'h15);
      sendByte(8'hF0);
      sendByte(8'h15);
      if (i == 254) checkOutput("wrap_cnt_255", key_cnt, 8'hFF);
    end
    checkOutput("wrap_cnt_0", key_cnt, 8'h00);
    checkOutput("wrap_key_down", key_down, 0);
    sendByte(8'h15);
    checkOutput("wrap_cnt_1", key_cnt, 8'h01);
    sendByte(8'hF0);
    sendByte(8'h15);

    sendByte(8'hE0);
    checkOutput("e0_ignored_down", key_down, 0);
    sendByte(8'h74);
    checkOutput("ext_key_code", key_code, 8'h74);
    checkOutput("ext_key_cnt", key_cnt, 8'h02);
    checkOutput("ext_key_down", key_down, 1);
    sendByte(8'hE0);
    sendByte(8'hF0);
    sendByte(8'h74);
    checkOutput("ext_release_down", key_down, 0);
    checkOutput("ext_release_cnt", key_cnt, 8'h02);

    checkOutput("pulses_never_both", bothCount, 0);
    checkOutput("pulses_one_cycle", longCount, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
    $finish;
  end

endmodule
